// File: rtl/wt_cache_pkg.sv
// Shared types and constants for the write-through cache memory-side logic.
// Contents:
//   arb_owner_t  - index of the cache port that owns a transaction
//   ARB_ICACHE   - port index of the instruction cache
//   ARB_DCACHE   - port index of the data cache
//   arb_state_e  - memory arbiter FSM states
package wt_cache_pkg;

  typedef logic arb_owner_t;

  localparam arb_owner_t ARB_ICACHE = 1'b0;
  localparam arb_owner_t ARB_DCACHE = 1'b1;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/wt_tid_pool.sv
// Transaction ID pool for the memory arbiter.
// It keeps the allocation bitmap, records which port owns each ID, and
// offers the lowest free ID. It also resolves return beats to their owner
// and flags returns that name an unallocated ID.
// Ports:
//   clk_i, rst_i     - clock, synchronous active-high reset
//   alloc_i          - allocate alloc_tid_i to alloc_owner_i at this edge
//   rtrn_vld_i/tid/last - return beat from the adapter
//   free_vld_o/tid_o - a free ID exists / lowest free ID
//   rtrn_hit_o       - return beat names an allocated ID
//   rtrn_owner_o     - owner of the returned ID
//   empty_o          - no ID allocated
//   err_o            - sticky: a return named an unallocated ID
module wt_tid_pool
  import wt_cache_pkg::*;
#(
  parameter int unsigned NumTx = 8,
  parameter int unsigned TidW  = $clog2(NumTx)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            alloc_i,
  input  logic [TidW-1:0] alloc_tid_i,
  input  arb_owner_t      alloc_owner_i,
  input  logic            rtrn_vld_i,
  input  logic [TidW-1:0] rtrn_tid_i,
  input  logic            rtrn_last_i,
  output logic            free_vld_o,
  output logic [TidW-1:0] free_tid_o,
  output logic            rtrn_hit_o,
  output arb_owner_t      rtrn_owner_o,
  output logic            empty_o,
  output logic            err_o
);

  logic [NumTx-1:0]       alloc_q, alloc_d;
  arb_owner_t [NumTx-1:0] owner_q;
  logic                   err_q;

  // Scan from the top so the lowest free index is the last one written.
  always_comb begin
    free_vld_o = 1'b0;
    free_tid_o = '0;
    for (int i = NumTx - 1; i >= 0; i--) begin
      if (!alloc_q[i]) begin
        free_vld_o = 1'b1;
        free_tid_o = TidW'(i);
      end
    end
  end

  assign rtrn_hit_o   = rtrn_vld_i & alloc_q[rtrn_tid_i];
  assign rtrn_owner_o = owner_q[rtrn_tid_i];
  assign empty_o      = (alloc_q == '0);
  assign err_o        = err_q;

  // The ID being allocated is free by construction, so a same-cycle free
  // can never target it; both updates simply apply.
  always_comb begin
    alloc_d = alloc_q;
    if (rtrn_hit_o && rtrn_last_i) alloc_d[rtrn_tid_i] = 1'b0;
    if (alloc_i)                   alloc_d[alloc_tid_i] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      alloc_q <= '0;
      owner_q <= '0;
      err_q   <= 1'b0;
    end else begin
      alloc_q <= alloc_d;
      if (alloc_i) owner_q[alloc_tid_i] <= alloc_owner_i;
      if (rtrn_vld_i && !alloc_q[rtrn_tid_i]) err_q <= 1'b1;
    end
  end

endmodule

// File: rtl/wt_mem_arbiter.sv
// Memory-side arbiter between the I$ (port 0) and D$ (port 1).
// Round-robin grant, held until the adapter acks; each accepted request
// gets a transaction ID and return beats are routed back by ID.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ARB_IDLE | no request presented; picks a winner and a free ID
//   ARB_BUSY | mem_req_o high for the latched winner/ID until mem_ack_i
//
// Ports:
//   clk_i, rst_i        - clock, synchronous active-high reset
//   quiesce_i           - block new grants (an open grant still completes)
//   req_i, req_data_i   - per-port request level and payload
//   ack_o               - per-port accept pulse, same cycle as mem_ack_i
//   mem_req_o/data/tid  - request to the memory adapter
//   mem_ack_i           - adapter accept
//   mem_rtrn_*          - return beats from the adapter
//   rtrn_vld_o, rtrn_o  - per-port return valid, broadcast payload
//   idle_o              - nothing outstanding and no request open
//   err_o               - sticky: return on an unallocated ID
module wt_mem_arbiter
  import wt_cache_pkg::*;
#(
  parameter int unsigned NumTx = 8,
  parameter int unsigned TidW  = $clog2(NumTx),
  parameter int unsigned ReqW  = 128,
  parameter int unsigned RtrnW = 160
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 quiesce_i,
  input  logic [1:0]           req_i,
  input  logic [1:0][ReqW-1:0] req_data_i,
  output logic [1:0]           ack_o,
  output logic                 mem_req_o,
  output logic [ReqW-1:0]      mem_data_o,
  output logic [TidW-1:0]      mem_tid_o,
  input  logic                 mem_ack_i,
  input  logic                 mem_rtrn_vld_i,
  input  logic [TidW-1:0]      mem_rtrn_tid_i,
  input  logic                 mem_rtrn_last_i,
  input  logic [RtrnW-1:0]     mem_rtrn_i,
  output logic [1:0]           rtrn_vld_o,
  output logic [RtrnW-1:0]     rtrn_o,
  output logic                 idle_o,
  output logic                 err_o
);

  arb_state_e      state_q, state_d;
  arb_owner_t      winner_q, winner_d;
  arb_owner_t      rr_q, rr_d;
  logic [TidW-1:0] tid_q, tid_d;

  logic            pool_alloc;
  logic            pool_free_vld;
  logic [TidW-1:0] pool_free_tid;
  logic            pool_hit;
  arb_owner_t      pool_owner;
  logic            pool_empty;

  wt_tid_pool #(
    .NumTx (NumTx),
    .TidW  (TidW)
  ) u_tid_pool (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .alloc_i       (pool_alloc),
    .alloc_tid_i   (tid_q),
    .alloc_owner_i (winner_q),
    .rtrn_vld_i    (mem_rtrn_vld_i),
    .rtrn_tid_i    (mem_rtrn_tid_i),
    .rtrn_last_i   (mem_rtrn_last_i),
    .free_vld_o    (pool_free_vld),
    .free_tid_o    (pool_free_tid),
    .rtrn_hit_o    (pool_hit),
    .rtrn_owner_o  (pool_owner),
    .empty_o       (pool_empty),
    .err_o         (err_o)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ARB_IDLE;
      winner_q <= ARB_ICACHE;
      rr_q     <= ARB_ICACHE;
      tid_q    <= '0;
    end else begin
      state_q  <= state_d;
      winner_q <= winner_d;
      rr_q     <= rr_d;
      tid_q    <= tid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    winner_d   = winner_q;
    rr_d       = rr_q;
    tid_d      = tid_q;
    mem_req_o  = 1'b0;
    mem_data_o = '0;
    mem_tid_o  = '0;
    ack_o      = 2'b00;
    pool_alloc = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if ((|req_i) && !quiesce_i && pool_free_vld) begin
          // With at least one request up, the non-preferred port must be
          // requesting whenever the preferred one is not.
          winner_d = req_i[rr_q] ? rr_q : ~rr_q;
          tid_d    = pool_free_tid;
          state_d  = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        mem_req_o  = 1'b1;
        mem_data_o = req_data_i[winner_q];
        mem_tid_o  = tid_q;
        if (mem_ack_i) begin
          ack_o[winner_q] = 1'b1;
          pool_alloc      = 1'b1;
          rr_d            = ~winner_q;
          state_d         = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    rtrn_vld_o = 2'b00;
    if (pool_hit) rtrn_vld_o[pool_owner] = 1'b1;
  end

  assign rtrn_o = mem_rtrn_i;
  assign idle_o = pool_empty & (state_q == ARB_IDLE);

endmodule

// File: tb/tb_wt_mem_arbiter.sv
module tb_wt_mem_arbiter;

  localparam int NumTx = 8;
  localparam int TidW  = 3;
  localparam int ReqW  = 128;
  localparam int RtrnW = 160;

  logic                 clk_i;
  logic                 rst_i;
  logic                 quiesce_i;
  logic [1:0]           req_i;
  logic [1:0][ReqW-1:0] req_data_i;
  logic [1:0]           ack_o;
  logic                 mem_req_o;
  logic [ReqW-1:0]      mem_data_o;
  logic [TidW-1:0]      mem_tid_o;
  logic                 mem_ack_i;
  logic                 mem_rtrn_vld_i;
  logic [TidW-1:0]      mem_rtrn_tid_i;
  logic                 mem_rtrn_last_i;
  logic [RtrnW-1:0]     mem_rtrn_i;
  logic [1:0]           rtrn_vld_o;
  logic [RtrnW-1:0]     rtrn_o;
  logic                 idle_o;
  logic                 err_o;

  wt_mem_arbiter #(
    .NumTx (NumTx), .TidW (TidW), .ReqW (ReqW), .RtrnW (RtrnW)
  ) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .quiesce_i       (quiesce_i),
    .req_i           (req_i),
    .req_data_i      (req_data_i),
    .ack_o           (ack_o),
    .mem_req_o       (mem_req_o),
    .mem_data_o      (mem_data_o),
    .mem_tid_o       (mem_tid_o),
    .mem_ack_i       (mem_ack_i),
    .mem_rtrn_vld_i  (mem_rtrn_vld_i),
    .mem_rtrn_tid_i  (mem_rtrn_tid_i),
    .mem_rtrn_last_i (mem_rtrn_last_i),
    .mem_rtrn_i      (mem_rtrn_i),
    .rtrn_vld_o      (rtrn_vld_o),
    .rtrn_o          (rtrn_o),
    .idle_o          (idle_o),
    .err_o           (err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Transaction-level reference: one open grant (or none), a set of
  // outstanding IDs with their owners, the preferred port and the error flag.
  bit              m_busy;
  bit              m_win;
  logic [TidW-1:0] m_tid;
  bit              m_alloc [NumTx];
  bit              m_owner [NumTx];
  bit              m_rr;
  bit              m_err;

  function automatic int lowest_free();
    for (int i = 0; i < NumTx; i++) if (!m_alloc[i]) return i;
    return -1;
  endfunction

  function automatic bit none_out();
    for (int i = 0; i < NumTx; i++) if (m_alloc[i]) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk_i) begin
    bit hit;
    int lf;
    if (rst_i) begin
      m_busy = 0; m_win = 0; m_tid = '0; m_rr = 0; m_err = 0;
      for (int i = 0; i < NumTx; i++) begin m_alloc[i] = 0; m_owner[i] = 0; end
    end else begin
      hit = mem_rtrn_vld_i && m_alloc[mem_rtrn_tid_i];
      lf  = lowest_free();
      if (mem_rtrn_vld_i && !m_alloc[mem_rtrn_tid_i]) m_err = 1;
      if (hit && mem_rtrn_last_i) m_alloc[mem_rtrn_tid_i] = 0;
      if (m_busy) begin
        if (mem_ack_i) begin
          m_alloc[m_tid] = 1;
          m_owner[m_tid] = m_win;
          m_rr   = !m_win;
          m_busy = 0;
        end
      end else if (req_i != 2'b00 && !quiesce_i && lf >= 0) begin
        m_busy = 1;
        m_win  = req_i[m_rr] ? m_rr : !m_rr;
        m_tid  = TidW'(lf);
      end
    end
  end

  always @(negedge clk_i) begin
    bit         hit;
    logic [1:0] e_ack;
    logic [1:0] e_rv;
    if (chk_en) begin
      hit   = mem_rtrn_vld_i && m_alloc[mem_rtrn_tid_i];
      e_ack = (m_busy && mem_ack_i) ? (2'b01 << m_win) : 2'b00;
      e_rv  = hit ? (2'b01 << m_owner[mem_rtrn_tid_i]) : 2'b00;
      chk("m_mem_req", mem_req_o, m_busy);
      chk("m_mem_tid", mem_tid_o, m_busy ? m_tid : '0);
      chk("m_mem_data", mem_data_o, m_busy ? req_data_i[m_win] : '0);
      chk("m_ack", ack_o, e_ack);
      chk("m_rtrn_vld", rtrn_vld_o, e_rv);
      chk("m_idle", idle_o, (!m_busy && none_out()));
      chk("m_err", err_o, m_err);
      if (hit) chk("m_rtrn_data", rtrn_o, mem_rtrn_i);
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic do_reset();
    rst_i = 1; req_i = 0; mem_ack_i = 0; quiesce_i = 0;
    mem_rtrn_vld_i = 0; mem_rtrn_last_i = 0; mem_rtrn_tid_i = 0;
    tick();
    rst_i = 0;
  endtask

  task automatic rtrn(input bit vld, input logic [TidW-1:0] tid, input bit last,
                      input logic [RtrnW-1:0] data);
    mem_rtrn_vld_i = vld; mem_rtrn_tid_i = tid; mem_rtrn_last_i = last; mem_rtrn_i = data;
  endtask

  initial begin
    rst_i = 1; quiesce_i = 0; req_i = 0; mem_ack_i = 0;
    req_data_i[0] = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    req_data_i[1] = 128'h9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0000;
    rtrn(0, 0, 0, 160'h0);
    tick(); tick();
    chk_en = 1;
    settle();
    chk("rst_mem_req", mem_req_o, 0);
    chk("rst_idle", idle_o, 1);
    chk("rst_err", err_o, 0);
    chk("rst_ack", ack_o, 2'b00);
    chk("rst_rtrn_vld", rtrn_vld_o, 2'b00);

    // Single I$ request, acked on the fourth request cycle.
    tick();
    rst_i = 0; req_i = 2'b01;
    settle(); chk("t1_req_cyc0", mem_req_o, 0);
    tick(); settle();
    chk("t1_req_cyc1", mem_req_o, 1);
    chk("t1_tid", mem_tid_o, 0);
    chk("t1_data", mem_data_o, 128'h1111_2222_3333_4444_5555_6666_7777_8888);
    tick(); tick(); settle(); chk("t1_req_cyc3", mem_req_o, 1);
    tick(); mem_ack_i = 1; settle();
    chk("t1_ack", ack_o, 2'b01);
    tick(); mem_ack_i = 0; req_i = 0; settle();
    chk("t1_req_after", mem_req_o, 0);
    chk("t1_not_idle", idle_o, 0);
    rtrn(1, 0, 1, 160'hABCDE_0123_4567_89AB_CDEF_0011_2233_4455_6677); settle();
    chk("t1_rtrn_vld", rtrn_vld_o, 2'b01);
    tick(); rtrn(0, 0, 0, 160'h0); settle();
    chk("t1_idle", idle_o, 1);

    // Both ports held, immediate acks: alternating winners, IDs 0..7.
    do_reset();
    req_i = 2'b11; mem_ack_i = 1;
    for (int g = 0; g < 8; g++) begin
      tick(); settle();
      chk("t2_ack", ack_o, (g % 2 == 0) ? 2'b01 : 2'b10);
      chk("t2_tid", mem_tid_o, g);
      tick();
    end
    // Pool full: no request, no ack despite mem_ack_i high.
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("t3_full_req", mem_req_o, 0);
      chk("t3_full_ack", ack_o, 2'b00);
      tick();
    end
    rtrn(1, 5, 1, 160'h5); settle();
    chk("t3_rtrn5_vld", rtrn_vld_o, 2'b10);
    tick(); rtrn(0, 0, 0, 160'h0); settle();
    chk("t3_freed_wait", mem_req_o, 0);
    tick(); settle();
    chk("t3_regrant_req", mem_req_o, 1);
    chk("t3_regrant_tid", mem_tid_o, 5);
    chk("t3_regrant_ack", ack_o, 2'b01);
    tick(); req_i = 0; mem_ack_i = 0;

    // D$-only grants, then a two-beat return on tid 2.
    do_reset();
    req_i = 2'b10; mem_ack_i = 1;
    for (int g = 0; g < 3; g++) begin
      tick(); settle();
      chk("t4_ack", ack_o, 2'b10);
      chk("t4_tid", mem_tid_o, g);
      tick();
    end
    req_i = 0; mem_ack_i = 0;
    rtrn(1, 2, 0, 160'hBEA7_0001); settle();
    chk("t4_beat1", rtrn_vld_o, 2'b10);
    tick(); rtrn(1, 2, 1, 160'hBEA7_0002); settle();
    chk("t4_beat2", rtrn_vld_o, 2'b10);
    chk("t4_beat2_data", rtrn_o, 160'hBEA7_0002);
    tick(); rtrn(1, 7, 1, 160'hDEAD); settle();
    chk("t4_bad_tid_vld", rtrn_vld_o, 2'b00);
    chk("t4_err_before", err_o, 0);
    tick(); rtrn(0, 0, 0, 160'h0); settle();
    chk("t4_err_set", err_o, 1);
    chk("t4_not_idle", idle_o, 0);
    req_i = 2'b01;
    tick(); settle();
    chk("t4_reuse_tid2", mem_tid_o, 2);
    mem_ack_i = 1; settle();
    chk("t4_reuse_ack", ack_o, 2'b01);
    tick(); mem_ack_i = 0; req_i = 0;

    // Quiesce raised during BUSY: grant completes, then no new request.
    req_i = 2'b01;
    tick(); quiesce_i = 1; settle();
    chk("t5_busy_req", mem_req_o, 1);
    tick(); mem_ack_i = 1; settle();
    chk("t5_ack", ack_o, 2'b01);
    chk("t5_tid", mem_tid_o, 3);
    tick(); mem_ack_i = 0;
    for (int k = 0; k < 3; k++) begin
      settle(); chk("t5_blocked", mem_req_o, 0); tick();
    end
    quiesce_i = 0;
    tick(); settle();
    chk("t5_resume", mem_req_o, 1);
    chk("t5_err_sticky", err_o, 1);

    // Reset while BUSY, then a stale return.
    rst_i = 1; req_i = 0;
    tick(); rst_i = 0; settle();
    chk("t6_req", mem_req_o, 0);
    chk("t6_idle", idle_o, 1);
    chk("t6_err_clr", err_o, 0);
    rtrn(1, 3, 1, 160'h3); settle();
    chk("t6_stale_vld", rtrn_vld_o, 2'b00);
    tick(); rtrn(0, 0, 0, 160'h0); settle();
    chk("t6_stale_err", err_o, 1);

    // Return naming the ID acked in the same cycle.
    do_reset();
    req_i = 2'b01;
    tick(); mem_ack_i = 1; rtrn(1, 0, 1, 160'h77); settle();
    chk("t7_ack", ack_o, 2'b01);
    chk("t7_rtrn_vld", rtrn_vld_o, 2'b00);
    tick(); mem_ack_i = 0; req_i = 0; rtrn(0, 0, 0, 160'h0); settle();
    chk("t7_err", err_o, 1);
    chk("t7_not_idle", idle_o, 0);

    // Free tid 0 and allocate tid 1 in the same cycle.
    req_i = 2'b10;
    tick(); mem_ack_i = 1; rtrn(1, 0, 1, 160'h88); settle();
    chk("t8_ack", ack_o, 2'b10);
    chk("t8_tid", mem_tid_o, 1);
    chk("t8_rtrn_vld", rtrn_vld_o, 2'b01);
    tick(); mem_ack_i = 0; req_i = 0; rtrn(0, 0, 0, 160'h0); settle();
    chk("t8_not_idle", idle_o, 0);
    rtrn(1, 1, 1, 160'h99); settle();
    chk("t8_rtrn1_vld", rtrn_vld_o, 2'b10);
    tick(); rtrn(0, 0, 0, 160'h0); settle();
    chk("t8_idle", idle_o, 1);

    tick(); tick();
    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
